// File: rtl/apu_aout_ctrl.sv
// Audio output controller: soft ramp to/from midscale, paced sample playback from a small FIFO,
// offset-binary conversion for the downstream sigma-delta modulator.
module apu_aout_ctrl #(
  parameter int unsigned W_SAMPLE   = 16,
  parameter int unsigned W_DIV      = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RAMP_STEP  = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_i,
  input  logic [W_DIV-1:0]              div_i,
  input  logic                          push_valid_i,
  output logic                          push_ready_o,
  input  logic [W_SAMPLE-1:0]           push_data_i,
  output logic [W_SAMPLE-1:0]           sdm_d_o,
  output logic                          busy_o,
  output logic                          underflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [W_SAMPLE-1:0] Mid   = {1'b1, {(W_SAMPLE-1){1'b0}}};
  localparam logic [W_SAMPLE-1:0] Step  = RAMP_STEP[W_SAMPLE-1:0];
  localparam logic [AW:0]         Depth = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {StIdle, StRampUp, StRun, StRampDown} state_e;

  state_e               state_q, state_d;
  logic [W_SAMPLE-1:0]  sdm_q, sdm_d;
  logic [3:0]           ramp_cnt_q;
  logic [W_DIV-1:0]     div_cnt_q, div_cnt_d;
  logic [AW:0]          level_q, level_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [W_SAMPLE-1:0]  mem_q [FIFO_DEPTH];

  logic                 ramp_tick, sample_tick, fifo_empty;
  logic                 push, pop, flush;
  logic [W_SAMPLE-1:0]  head;
  logic [W_SAMPLE:0]    up_sum;
  logic [W_SAMPLE-1:0]  ramp_up_val, ramp_dn_val;

  assign ramp_tick    = (ramp_cnt_q == 4'hF);
  assign fifo_empty   = (level_q == '0);
  assign sample_tick  = (state_q == StRun) && (div_cnt_q == '0);
  // Ready uses pre-pop occupancy, so a full FIFO stays closed even on a popping tick.
  assign push_ready_o = ((state_q == StRampUp) || (state_q == StRun)) && (level_q < Depth);
  assign push         = push_valid_i && push_ready_o;
  assign pop          = sample_tick && !fifo_empty;
  assign underflow_o  = sample_tick && fifo_empty;
  assign busy_o       = (state_q != StIdle);
  assign sdm_d_o      = sdm_q;
  assign level_o      = level_q;
  assign head         = mem_q[rd_ptr_q];

  assign up_sum      = {1'b0, sdm_q} + {1'b0, Step};
  assign ramp_up_val = (up_sum >= {1'b0, Mid}) ? Mid : up_sum[W_SAMPLE-1:0];
  assign ramp_dn_val = (sdm_q >= Step) ? (sdm_q - Step) : '0;

  always_comb begin
    state_d   = state_q;
    sdm_d     = sdm_q;
    div_cnt_d = div_cnt_q;
    flush     = 1'b0;
    if (pop) begin
      sdm_d = {~head[W_SAMPLE-1], head[W_SAMPLE-2:0]};
    end
    case (state_q)
      StIdle: begin
        if (en_i) state_d = StRampUp;
      end
      StRampUp: begin
        if (!en_i) begin
          state_d = StRampDown;
          flush   = 1'b1;
        end else if (ramp_tick) begin
          sdm_d = ramp_up_val;
          if (ramp_up_val == Mid) begin
            state_d   = StRun;
            div_cnt_d = div_i;
          end
        end
      end
      StRun: begin
        div_cnt_d = sample_tick ? div_i : (div_cnt_q - 1'b1);
        if (!en_i) begin
          state_d = StRampDown;
          flush   = 1'b1;
        end
      end
      StRampDown: begin
        if (ramp_tick) begin
          sdm_d = ramp_dn_val;
          if (ramp_dn_val == '0) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    level_d  = level_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      level_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) begin
        level_d = level_q + 1'b1;
      end else if (pop && !push) begin
        level_d = level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sdm_q      <= '0;
      ramp_cnt_q <= '0;
      div_cnt_q  <= '0;
      level_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      sdm_q      <= sdm_d;
      ramp_cnt_q <= ramp_cnt_q + 4'd1;
      div_cnt_q  <= div_cnt_d;
      level_q    <= level_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: tb/tb_apu_aout_ctrl.sv
// Bench for apu_aout_ctrl: directed sequences and a vector table, plus randomized traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_apu_aout_ctrl;

  localparam int W    = 16;
  localparam int WD   = 12;
  localparam int D    = 4;
  localparam int STEP = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [WD-1:0] div;
  logic          pv;
  logic          pr;
  logic [W-1:0]  pd;
  logic [W-1:0]  sdm;
  logic          busy;
  logic          uf;
  logic [2:0]    lvl;

  always #5 clk = ~clk;

  apu_aout_ctrl #(
    .W_SAMPLE   (W),
    .W_DIV      (WD),
    .FIFO_DEPTH (D),
    .RAMP_STEP  (STEP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en),
    .div_i        (div),
    .push_valid_i (pv),
    .push_ready_o (pr),
    .push_data_i  (pd),
    .sdm_d_o      (sdm),
    .busy_o       (busy),
    .underflow_o  (uf),
    .level_o      (lvl)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Behavioural model: mode 0 idle, 1 ramping up, 2 playing, 3 ramping down.
  int           m_mode;
  int           m_sdm;
  logic [W-1:0] m_q[$];
  int           m_phase;
  int           m_cd;
  bit           m_tick_last;
  bit           m_pop_last;

  function automatic void m_reset();
    m_mode  = 0;
    m_sdm   = 0;
    m_q.delete();
    m_phase = 0;
    m_cd    = 0;
  endfunction

  function automatic bit m_ready();
    return ((m_mode == 1) || (m_mode == 2)) && (m_q.size() < D);
  endfunction

  function automatic bit m_tick();
    return (m_mode == 2) && (m_cd == 0);
  endfunction

  function automatic void m_step(bit e, int dv, bit v, logic [W-1:0] d);
    bit rdy;
    bit tk;
    bit rt;
    rdy = m_ready();
    tk  = m_tick();
    rt  = (m_phase == 15);
    m_tick_last = tk;
    m_pop_last  = 1'b0;
    if (tk && (m_q.size() > 0)) begin
      logic [W-1:0] s;
      s = m_q.pop_front();
      m_sdm = (int'(s) + 32768) % 65536;
      m_pop_last = 1'b1;
    end
    if (v && rdy) m_q.push_back(d);
    case (m_mode)
      0: if (e) m_mode = 1;
      1: begin
        if (!e) begin
          m_mode = 3;
          m_q.delete();
        end else if (rt) begin
          m_sdm = (m_sdm + STEP > 32768) ? 32768 : m_sdm + STEP;
          if (m_sdm == 32768) begin
            m_mode = 2;
            m_cd   = dv;
          end
        end
      end
      2: begin
        m_cd = tk ? dv : m_cd - 1;
        if (!e) begin
          m_mode = 3;
          m_q.delete();
        end
      end
      default: begin
        if (rt) begin
          m_sdm = (m_sdm >= STEP) ? m_sdm - STEP : 0;
          if (m_sdm == 0) m_mode = 0;
        end
      end
    endcase
    m_phase = (m_phase + 1) % 16;
  endfunction

  // One clock: drive inputs, compare all outputs to the model, advance both.
  task automatic cyc(input bit e, input int dv, input bit v, input logic [W-1:0] d);
    en  = e;
    div = dv[WD-1:0];
    pv  = v;
    pd  = d;
    chk("sdm", sdm, m_sdm);
    chk("busy", busy, m_mode != 0);
    chk("level", lvl, m_q.size());
    chk("push_ready", pr, m_ready());
    chk("underflow", uf, m_tick() && (m_q.size() == 0));
    @(posedge clk);
    m_step(e, dv, v, d);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    pv    = 1'b0;
    div   = '0;
    pd    = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_sdm", sdm, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", lvl, 0);
    chk("rst_ready", pr, 0);
    chk("rst_underflow", uf, 0);
    rst_n = 1'b1;
    m_reset();
  endtask

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] exp;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl [5];
    logic [W-1:0] exp_dn [3];
    int           uf_cnt;
    int           pi;
    int           qi;
    int           last_pop;
    int           t;
    int           di;
    int           prev;
    bit           found;
    bit           e;

    tbl[0] = '{16'h0000, 16'h8000};
    tbl[1] = '{16'h7FFF, 16'hFFFF};
    tbl[2] = '{16'h8000, 16'h0000};
    tbl[3] = '{16'h1234, 16'h9234};
    tbl[4] = '{16'hFFFF, 16'h7FFF};
    exp_dn[0] = 16'h0150;
    exp_dn[1] = 16'h0050;
    exp_dn[2] = 16'h0000;

    m_reset();
    do_reset();

    // Ramp-up from reset with en high from the first cycle.
    for (int k = 1; k <= 2048; k++) begin
      cyc(1'b1, 3, 1'b0, '0);
      if (k == 16)   chk("ramp_first", sdm, 16'h0100);
      if (k == 2047) chk("ramp_pre_mid", sdm, 16'h7F00);
    end
    chk("ramp_mid", sdm, 16'h8000);
    chk("ramp_busy", busy, 1);

    // Empty FIFO, div=3: underflow every 4 cycles, output holds.
    uf_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (uf) uf_cnt++;
      cyc(1'b1, 3, 1'b0, '0);
    end
    chk("uf_count", uf_cnt, 3);
    chk("uf_hold", sdm, 16'h8000);

    // Conversion table with div=9 pacing.
    pi = 0;
    qi = 0;
    last_pop = 0;
    t = 0;
    while ((qi < 5) && (t < 200)) begin
      bit acc;
      acc = (pi < 5) && m_ready();
      cyc(1'b1, 9, pi < 5, (pi < 5) ? tbl[pi].din : 16'h0000);
      t++;
      if (acc) pi++;
      if (m_pop_last) begin
        chk("conv", sdm, tbl[qi].exp);
        if (qi > 0) chk("tick_gap", t - last_pop, 10);
        last_pop = t;
        qi++;
      end
    end
    chk("conv_done", qi, 5);

    // Full FIFO: fill right after a tick, then hold push_valid across the next tick.
    t = 0;
    do begin
      cyc(1'b1, 30, 1'b0, '0);
      t++;
    end while (!m_tick_last && (t < 100));
    for (int i = 0; i < 4; i++) cyc(1'b1, 30, 1'b1, 16'h1000 + 16'(i));
    chk("full_level", lvl, 4);
    chk("full_ready", pr, 0);
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (m_tick()) begin
        chk("tick_full_level", lvl, 4);
        chk("tick_full_ready", pr, 0);
        cyc(1'b1, 30, 1'b1, 16'h2222);
        chk("post_tick_level", lvl, 3);
        chk("post_tick_ready", pr, 1);
        found = 1'b1;
        break;
      end
      cyc(1'b1, 30, 1'b1, 16'h2222);
    end
    chk("full_tick_seen", found, 1);

    // Stop from RUN with sdm=0x0250 and two queued samples.
    t = 0;
    do begin
      cyc(1'b1, 5, 1'b0, '0);
      t++;
    end while (!((m_q.size() == 0) && m_tick_last) && (t < 400));
    cyc(1'b1, 5, 1'b1, 16'h8250);
    t = 0;
    do begin
      cyc(1'b1, 5, 1'b0, '0);
      t++;
    end while (!m_pop_last && (t < 20));
    chk("stop_start", sdm, 16'h0250);
    cyc(1'b1, 5, 1'b1, 16'h1111);
    cyc(1'b1, 5, 1'b1, 16'h2222);
    chk("stop_level", lvl, 2);
    cyc(1'b0, 5, 1'b0, '0);
    chk("flush", lvl, 0);
    di = 0;
    prev = m_sdm;
    for (int k = 0; k < 100; k++) begin
      cyc(1'b1, 5, 1'b0, '0);  // en is ignored while ramping down
      if (m_sdm != prev) begin
        chk("ramp_dn", sdm, (di < 3) ? exp_dn[di] : 16'hDEAD);
        di++;
        prev = m_sdm;
      end
      if (m_mode == 0) break;
    end
    chk("dn_steps", di, 3);
    chk("idle_busy", busy, 0);

    // Randomized traffic.
    do_reset();
    e = 1'b1;
    for (int k = 0; k < 9000; k++) begin
      if (e && ($urandom_range(0, 1499) == 0)) e = 1'b0;
      else if (!e && ($urandom_range(0, 49) == 0)) e = 1'b1;
      cyc(e, $urandom_range(0, 5), $urandom_range(0, 2) != 0, 16'($urandom));
    end

    // Asynchronous reset in the middle of playback.
    t = 0;
    while ((m_mode != 2) && (t < 4500)) begin
      cyc(1'b1, 2, 1'b1, 16'($urandom));
      t++;
    end
    for (int k = 0; k < 5; k++) cyc(1'b1, 2, 1'b1, 16'($urandom));
    chk("pre_reset_run", m_mode, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_sdm", sdm, 0);
    chk("async_busy", busy, 0);
    chk("async_level", lvl, 0);
    chk("async_ready", pr, 0);
    chk("async_underflow", uf, 0);
    @(posedge clk);
    #1;
    chk("held_sdm", sdm, 0);
    rst_n = 1'b1;
    m_reset();
    cyc(1'b1, 0, 1'b0, '0);
    chk("resume_busy", busy, 1);
    for (int k = 0; k < 40; k++) cyc(1'b1, 0, 1'b1, 16'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apu_aout_ctrl.md
APU_AOUT_CTRL -- requirements
Module: apu_aout_ctrl

Interface
REQ-001 Parameter W_SAMPLE, default 16: sample width in bits.
REQ-002 Parameter W_DIV, default 12: sample-period divider width.
REQ-003 Parameter FIFO_DEPTH, default 4: sample FIFO depth; a power of 2, at least 2.
REQ-004 Parameter RAMP_STEP, default 256: ramp increment per ramp tick; divides 2^(W_SAMPLE-1) exactly.
REQ-005 clk  in  1  clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 en  in  1  playback enable, level-sensitive.
REQ-008 div  in  W_DIV  sample period minus 1, in clk cycles.
REQ-009 push_valid  in  1  producer has a sample.
REQ-010 push_ready  out  1  controller accepts a sample this cycle.
REQ-011 push_data  in  W_SAMPLE  signed two's-complement sample.
REQ-012 sdm_d  out  W_SAMPLE  unsigned offset-binary level to sigma-delta modulator, registered.
REQ-013 busy  out  1  high when state is not IDLE.
REQ-014 underflow  out  1  one-cycle pulse on a sample tick with the FIFO empty.
REQ-015 level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 The state machine SHALL have the states IDLE, RAMP_UP, RUN and RAMP_DOWN.
REQ-017 IDLE -> RAMP_UP SHALL occur on the first cycle en=1.
REQ-018 RAMP_UP -> RUN SHALL occur on the ramp tick where sdm_d reaches 2^(W_SAMPLE-1) (midscale, 0x8000).
REQ-019 RAMP_UP or RUN -> RAMP_DOWN SHALL occur on the first cycle en=0.
REQ-020 RAMP_DOWN -> IDLE SHALL occur on the ramp tick where sdm_d reaches 0; en is ignored during RAMP_DOWN.
REQ-021 The ramp tick SHALL be generated by a free-running 4-bit counter, reset 0, incrementing every cycle; the tick is active when the counter equals 15, so there is one tick per 16 cycles.
REQ-022 RAMP_UP on a ramp tick: sdm_d SHALL be set to min(sdm_d+RAMP_STEP, 0x8000).
REQ-023 RAMP_DOWN on a ramp tick: sdm_d SHALL be set to sdm_d-RAMP_STEP if sdm_d >= RAMP_STEP, else 0.
REQ-024 The sample divider SHALL be loaded with div on the RUN entry cycle, decrement by 1 each RUN cycle, and reload div on the cycle it equals 0; that cycle is a sample tick, so the tick period is div+1 cycles.
REQ-025 When div=0, a sample tick SHALL occur on every RUN cycle.
REQ-026 div SHALL be sampled only at load and reload; a mid-period change takes effect at the next reload.
REQ-027 On a sample tick with the FIFO non-empty, the head SHALL be popped and sdm_d SHALL be set to {~push_data[MSB], push_data[MSB-1:0]} of that entry on the next edge.
REQ-028 On a sample tick with the FIFO empty, sdm_d SHALL hold its value and underflow SHALL pulse high for 1 cycle.
REQ-029 A push SHALL be accepted when push_valid && push_ready.
REQ-030 push_ready SHALL be (state==RAMP_UP || state==RUN) && level<FIFO_DEPTH, computed from pre-pop occupancy with no same-cycle bypass.
REQ-031 A simultaneous push and pop SHALL leave level unchanged.
REQ-032 A push into an empty FIFO SHALL NOT satisfy a same-cycle tick; that tick is an underflow.
REQ-033 The FIFO SHALL be flushed (level=0) on the cycle of entry into RAMP_DOWN.
REQ-034 A sample tick SHALL NOT occur outside RUN.
REQ-035 When en falls in RAMP_UP, the ramp-down SHALL start from the current sdm_d.
REQ-036 busy SHALL be combinational from the state register.

Reset
REQ-037 While rst_n=0: state=IDLE, sdm_d=0, level=0, push_ready=0, underflow=0, busy=0, ramp counter=0, divider=0.
REQ-038 Reset assertion mid-RUN or mid-ramp SHALL abandon the operation immediately with no ramp-down.
REQ-039 Operation SHALL resume from IDLE on the first clock after release.

Verification
REQ-040 Ramp-up: reset, en=1 at cycle 0 -> sdm_d steps 0x0100 every 16 cycles; RUN entered after 128 ticks (sdm_d=0x8000); busy=1 throughout.
REQ-041 Conversion and pacing: div=9, push 0x0000, 0x7FFF, 0x8000 in RUN -> sdm_d takes 0x8000, 0xFFFF, 0x0000 on successive ticks 10 cycles apart.
REQ-042 Underflow: RUN with an empty FIFO, div=3 -> underflow pulses every 4 cycles; sdm_d holds its last value.
REQ-043 Full FIFO: fill 4 entries without a tick -> push_ready=0, level=4; on a tick in which push_valid=1, no push is accepted; next cycle level=3 and push_ready=1.
REQ-044 Stop: RUN with sdm_d=0x0250, level=2, en=0 -> level=0 next cycle; sdm_d goes 0x0150, 0x0050, 0x0000 on ramp ticks; then IDLE, busy=0.
REQ-045 Reset mid-RUN: rst_n pulsed low -> all outputs equal the REQ-037 values asynchronously, with no ramp.
